// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction fetch controller with PC, 2-entry fetch queue and FSM
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] out_pc,
  output logic [1:0]  state,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [15:0] C_RESET_PC = {RESET_PC[15:2], 2'b00};

  state_t      state_d, state_q;
  logic [15:0] pc_d, pc_q;
  logic [1:0]  count_d, count_q;
  logic [15:0] fetch_count_d, fetch_count_q;
  logic [15:0] head_pc_d, head_pc_q;
  logic [31:0] head_instr_d, head_instr_q;
  logic [15:0] tail_pc_d, tail_pc_q;
  logic [31:0] tail_instr_d, tail_instr_q;

  logic w_pop;
  logic w_fetch;
  logic w_fetch_to_head;

  assign out_valid = (count_q != 2'd0);
  assign w_pop     = out_valid && out_ready;
  assign w_fetch   = (state_q == ST_RUN) && !redirect_valid
                     && ((count_q < 2'd2) || w_pop);
  // The new entry lands in whichever slot is free once a same-cycle pop has shifted.
  assign w_fetch_to_head = (count_q == 2'd0) || ((count_q == 2'd1) && w_pop);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q;
    head_pc_d     = head_pc_q;
    head_instr_d  = head_instr_q;
    tail_pc_d     = tail_pc_q;
    tail_instr_d  = tail_instr_q;

    if (redirect_valid) begin
      pc_d    = {redirect_pc[15:2], 2'b00};
      count_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: if (start)    state_d = ST_RUN;
        ST_RUN:  if (halt_req) state_d = ST_HALT;
        ST_HALT: if (start)    state_d = ST_RUN;
        default:               state_d = ST_IDLE;
      endcase

      if (w_pop) begin
        head_pc_d    = tail_pc_q;
        head_instr_d = tail_instr_q;
      end

      if (w_fetch) begin
        pc_d          = pc_q + 16'd4;
        fetch_count_d = fetch_count_q + 16'd1;
        if (w_fetch_to_head) begin
          head_pc_d    = pc_q;
          head_instr_d = imem_rdata;
        end else begin
          tail_pc_d    = pc_q;
          tail_instr_d = imem_rdata;
        end
      end

      count_d = count_q + {1'b0, w_fetch} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= C_RESET_PC;
      count_q       <= 2'd0;
      fetch_count_q <= 16'd0;
      head_pc_q     <= 16'd0;
      head_instr_q  <= 32'd0;
      tail_pc_q     <= 16'd0;
      tail_instr_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      fetch_count_q <= fetch_count_d;
      head_pc_q     <= head_pc_d;
      head_instr_q  <= head_instr_d;
      tail_pc_q     <= tail_pc_d;
      tail_instr_q  <= tail_instr_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_instr   = head_instr_q;
  assign out_pc      = head_pc_q;
  assign state       = state_q;
  assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl (vector table + corner sequences)
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt_req, redirect_valid, out_ready;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic [1:0]  state;
  logic [15:0] fetch_count;

  logic        start2;
  logic [15:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic [15:0] out_pc2;
  logic [1:0]  state2;
  logic [15:0] fetch_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    case (a[15:2])
      14'd0:   rom_word = 32'h00300413;
      14'd1:   rom_word = 32'h00100493;
      default: rom_word = {~a, a};
    endcase
  endfunction

  assign imem_rdata  = rom_word(imem_addr);
  assign imem_rdata2 = rom_word(imem_addr2);

  fetch_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .state(state), .fetch_count(fetch_count)
  );

  fetch_ctrl #(.RESET_PC(16'hFFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .halt_req(1'b0),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .out_valid(out_valid2), .out_ready(1'b1),
    .out_instr(out_instr2), .out_pc(out_pc2),
    .state(state2), .fetch_count(fetch_count2)
  );

  typedef struct {
    logic        start;
    logic        halt;
    logic        redir;
    logic [15:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [1:0]  e_state;
    logic [15:0] e_addr;
    logic [15:0] e_fc;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic s, input logic h, input logic r,
                              input logic [15:0] rpc, input logic rdy,
                              input logic ev, input logic [15:0] epc,
                              input logic [1:0] est, input logic [15:0] ea,
                              input logic [15:0] efc);
    vec_t v;
    v.start = s;  v.halt = h;  v.redir = r;  v.rpc = rpc;  v.rdy = rdy;
    v.e_valid = ev;  v.e_pc = epc;  v.e_state = est;  v.e_addr = ea;  v.e_fc = efc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Each row: inputs for one cycle, then the registered view after that edge.
    vecs[0]  = mk(1, 0, 0, 16'h0000, 1,  0, 16'h0000, 2'd1, 16'h0000, 16'd0);
    vecs[1]  = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0000, 2'd1, 16'h0004, 16'd1);
    vecs[2]  = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0004, 2'd1, 16'h0008, 16'd2);
    vecs[3]  = mk(0, 0, 1, 16'h0000, 1,  0, 16'h0000, 2'd1, 16'h0000, 16'd2);
    vecs[4]  = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0000, 2'd1, 16'h0004, 16'd3);
    vecs[5]  = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0000, 2'd1, 16'h0008, 16'd4);
    vecs[6]  = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0000, 2'd1, 16'h0008, 16'd4);
    vecs[7]  = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0000, 2'd1, 16'h0008, 16'd4);
    vecs[8]  = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0000, 2'd1, 16'h0008, 16'd4);
    vecs[9]  = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0004, 2'd1, 16'h000C, 16'd5);
    vecs[10] = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0008, 2'd1, 16'h0010, 16'd6);
    vecs[11] = mk(0, 0, 1, 16'h0000, 1,  0, 16'h0000, 2'd1, 16'h0000, 16'd6);
    vecs[12] = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0000, 2'd1, 16'h0004, 16'd7);
    vecs[13] = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0000, 2'd1, 16'h0008, 16'd8);
    vecs[14] = mk(0, 0, 1, 16'h0023, 0,  0, 16'h0000, 2'd1, 16'h0020, 16'd8);
    vecs[15] = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0020, 2'd1, 16'h0024, 16'd9);
    vecs[16] = mk(0, 0, 1, 16'h000C, 0,  0, 16'h0000, 2'd1, 16'h000C, 16'd9);
    vecs[17] = mk(0, 1, 0, 16'h0000, 0,  1, 16'h000C, 2'd2, 16'h0010, 16'd10);
    vecs[18] = mk(0, 0, 0, 16'h0000, 0,  1, 16'h000C, 2'd2, 16'h0010, 16'd10);
    vecs[19] = mk(0, 0, 0, 16'h0000, 1,  0, 16'h0000, 2'd2, 16'h0010, 16'd10);
    vecs[20] = mk(1, 0, 0, 16'h0000, 1,  0, 16'h0000, 2'd1, 16'h0010, 16'd10);
    vecs[21] = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0010, 2'd1, 16'h0014, 16'd11);
    vecs[22] = mk(1, 1, 0, 16'h0000, 1,  1, 16'h0014, 2'd2, 16'h0018, 16'd12);
    vecs[23] = mk(1, 1, 0, 16'h0000, 1,  0, 16'h0000, 2'd1, 16'h0018, 16'd12);
    vecs[24] = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0018, 2'd1, 16'h001C, 16'd13);
    vecs[25] = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0018, 2'd1, 16'h0020, 16'd14);

    rst_n = 1'b0;
    start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 16'h0000; out_ready = 1'b0; start2 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid",   {31'd0, out_valid},   32'd0);
    check("reset state",       {30'd0, state},       32'd0);
    check("reset pc",          {16'd0, imem_addr},   32'h0000);
    check("reset fetch_count", {16'd0, fetch_count}, 32'd0);
    check("reset out_pc",      {16'd0, out_pc},      32'd0);
    check("reset out_instr",   out_instr,            32'd0);
    check("reset pc wrapdut",  {16'd0, imem_addr2},  32'h0000FFFC);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      start          = vecs[i].start;
      halt_req       = vecs[i].halt;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("row%0d state", i), {30'd0, state}, {30'd0, vecs[i].e_state});
      check($sformatf("row%0d pc", i), {16'd0, imem_addr}, {16'd0, vecs[i].e_addr});
      check($sformatf("row%0d fetch_count", i), {16'd0, fetch_count}, {16'd0, vecs[i].e_fc});
      if (vecs[i].e_valid) begin
        check($sformatf("row%0d out_pc", i), {16'd0, out_pc}, {16'd0, vecs[i].e_pc});
        check($sformatf("row%0d out_instr", i), out_instr, rom_word(vecs[i].e_pc));
      end
      if (i == 1) check("first instr word", out_instr, 32'h00300413);
      if (i == 2) check("second instr word", out_instr, 32'h00100493);
    end

    // Asynchronous reset in the middle of a full-queue burst.
    start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid",   {31'd0, out_valid},   32'd0);
    check("midreset state",       {30'd0, state},       32'd0);
    check("midreset fetch_count", {16'd0, fetch_count}, 32'd0);
    check("midreset pc",          {16'd0, imem_addr},   32'h0000);
    check("midreset out_pc",      {16'd0, out_pc},      32'd0);
    check("midreset out_instr",   out_instr,            32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset idle state", {30'd0, state},       32'd0);
    check("post-reset no fetch",   {16'd0, fetch_count}, 32'd0);
    check("post-reset out_valid",  {31'd0, out_valid},   32'd0);

    // PC wrap from a top-of-memory reset address.
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    check("wrap state run",  {30'd0, state2},     32'd1);
    check("wrap idle empty", {31'd0, out_valid2}, 32'd0);
    @(posedge clk);
    #1;
    check("wrap head0 valid", {31'd0, out_valid2}, 32'd1);
    check("wrap head0 pc",    {16'd0, out_pc2},    32'h0000FFFC);
    check("wrap head0 instr", out_instr2,          rom_word(16'hFFFC));
    check("wrap pc after",    {16'd0, imem_addr2}, 32'h00000000);
    @(posedge clk);
    #1;
    check("wrap head1 pc",    {16'd0, out_pc2},    32'h00000000);
    check("wrap head1 instr", out_instr2,          32'h00300413);
    @(posedge clk);
    #1;
    check("wrap head2 pc",    {16'd0, out_pc2},    32'h00000004);
    check("wrap fetch_count", {16'd0, fetch_count2}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
